// File: rtl/fifo_pkg.sv
// Shared constants and types for the upstream-FIFO read-side environment.
package fifo_pkg;

  localparam int unsigned DATA_W_DEF  = 8;
  localparam int unsigned PKT_LEN_DEF = 4;
  localparam int unsigned BUF_DEPTH   = 3;

  typedef logic [1:0] buf_idx_t;

  function automatic buf_idx_t idx_next(input buf_idx_t idx);
    return (idx == buf_idx_t'(BUF_DEPTH - 1)) ? '0 : idx + 1'b1;
  endfunction

endpackage

// File: rtl/fifo_rd_skid.sv
// Three-entry FIFO-ordered skid buffer; head entry is presented on o_data.
module fifo_rd_skid
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clear,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid,
  output buf_idx_t          o_count
);

  logic [DATA_W-1:0] r_mem [BUF_DEPTH];
  buf_idx_t          r_rd_ptr;
  buf_idx_t          r_wr_ptr;
  buf_idx_t          r_count;
  logic              w_pop;
  logic              w_push;

  assign w_pop  = i_pop && (r_count != '0);
  // A push into a full buffer is only allowed when the head leaves the same edge.
  assign w_push = i_push && ((r_count != buf_idx_t'(BUF_DEPTH)) || w_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < BUF_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (i_clear) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= idx_next(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= idx_next(r_rd_ptr);
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_valid = (r_count != '0);
  assign o_count = r_count;

endmodule

// File: rtl/fifo_rd_stream.sv
// Converts a synchronous FIFO read port into a valid/ready stream.
// Optional packet framing on m_last is enabled by defining FIFO_RD_LAST_EN.
module fifo_rd_stream
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned PKT_LEN = PKT_LEN_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              empty,
  input  logic [DATA_W-1:0] data_out,
  output logic              rd_en,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic [1:0]        buf_count
);

  logic     r_run;
  logic     r_inflight;
  logic     w_rd_en;
  logic     w_valid;
  logic     w_xfer;
  buf_idx_t w_count;
  logic [2:0] w_occupancy;

  // Reads are gated only by registered occupancy, keeping m_ready off the rd_en path.
  assign w_occupancy = {1'b0, w_count} + {2'b00, r_inflight};
  assign w_rd_en     = r_run && !empty && !flush && (w_occupancy < 3'(BUF_DEPTH));
  assign w_xfer      = w_valid && m_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run      <= 1'b0;
      r_inflight <= 1'b0;
    end else begin
      r_run      <= 1'b1;
      r_inflight <= w_rd_en;
    end
  end

  fifo_rd_skid #(
    .DATA_W (DATA_W)
  ) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clear (flush),
    .i_push  (r_inflight),
    .i_data  (data_out),
    .i_pop   (w_xfer),
    .o_data  (m_data),
    .o_valid (w_valid),
    .o_count (w_count)
  );

`ifdef FIFO_RD_LAST_EN
  localparam int unsigned BEAT_W = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;

  logic [BEAT_W-1:0] r_beat;
  logic              w_beat_end;

  assign w_beat_end = (r_beat == BEAT_W'(PKT_LEN - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_beat <= '0;
    end else if (flush) begin
      r_beat <= '0;
    end else if (w_xfer) begin
      r_beat <= w_beat_end ? '0 : r_beat + 1'b1;
    end
  end

  assign m_last = w_valid && w_beat_end;
`else
  assign m_last = 1'b0;
`endif

  assign rd_en     = w_rd_en;
  assign m_valid   = w_valid;
  assign buf_count = w_count;

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream with a behavioural upstream FIFO model.
module tb_fifo_rd_stream;

`ifdef FIFO_RD_LAST_EN
  localparam bit LAST_EN = 1'b1;
`else
  localparam bit LAST_EN = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       flush;
  logic       empty;
  logic [7:0] data_out;
  logic       rd_en;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_data;
  logic       m_last;
  logic [1:0] buf_count;

  fifo_rd_stream #(
    .DATA_W  (8),
    .PKT_LEN (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .empty     (empty),
    .data_out  (data_out),
    .rd_en     (rd_en),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_last    (m_last),
    .buf_count (buf_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  logic [7:0]  fq[$];
  logic [7:0]  out_data[$];
  logic        out_last[$];
  int          out_cyc[$];
  logic [7:0]  exp_q[$];
  int          cyc_n    = 0;
  int          first_rd = -1;
  int unsigned n_acc    = 0;
  int unsigned exp_beat = 0;
  logic        hold_pend = 1'b0;
  logic [7:0]  hold_data;
  logic        hold_last;

  task automatic check(input string tag, input int unsigned act, input int unsigned exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic load(input logic [7:0] w);
    fq.push_back(w);
    empty = 1'b0;
  endtask

  task automatic clear_log();
    out_data.delete();
    out_last.delete();
    out_cyc.delete();
    exp_q.delete();
    first_rd = -1;
    n_acc    = 0;
  endtask

  // One clock: sample handshake at negedge, update FIFO model after posedge.
  task automatic cyc();
    logic acc;
    @(negedge clk);
    acc = rd_en && !empty;
    if (acc && first_rd < 0) first_rd = cyc_n;
    if (acc) n_acc++;
    if (hold_pend && m_valid) begin
      check("hold_data", m_data, hold_data);
      check("hold_last", m_last, hold_last);
    end
    hold_pend = m_valid && !m_ready;
    hold_data = m_data;
    hold_last = m_last;
    if (m_valid && m_ready) begin
      out_data.push_back(m_data);
      out_last.push_back(m_last);
      out_cyc.push_back(cyc_n);
    end
    @(posedge clk);
    #1;
    if (acc) data_out = fq.pop_front();
    empty = (fq.size() == 0);
    cyc_n++;
    #1;
  endtask

  task automatic run_until(input int unsigned n, input int unsigned budget, input string tag);
    int unsigned k = 0;
    while (out_data.size() < n && k < budget) begin
      cyc();
      k++;
    end
    check(tag, out_data.size(), n);
  endtask

  task automatic check_log(input string tag, input bit consec);
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < out_data.size()) begin
        check($sformatf("%s_data%0d", tag, i), out_data[i], exp_q[i]);
        check($sformatf("%s_last%0d", tag, i), out_last[i],
              (LAST_EN && exp_beat == 3) ? 1 : 0);
        if (consec && i > 0)
          check($sformatf("%s_gap%0d", tag, i), out_cyc[i] - out_cyc[i-1], 1);
      end
      exp_beat = (exp_beat + 1) % 4;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n    = 1'b1;
    flush    = 1'b0;
    empty    = 1'b1;
    data_out = 8'h00;
    m_ready  = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_rd_en",   rd_en,     0);
    check("rst_m_valid", m_valid,   0);
    check("rst_m_data",  m_data,    0);
    check("rst_m_last",  m_last,    0);
    check("rst_count",   buf_count, 0);

    // Basic packet: 11,22,33,44 streamed back to back.
    clear_log();
    load(8'h11); load(8'h22); load(8'h33); load(8'h44);
    m_ready = 1'b1;
    #9 rst_n = 1'b1;
    #1 check("t1_rd_before_edge", rd_en, 0);
    run_until(4, 20, "t1_count");
    exp_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    check_log("t1", 1'b1);
    if (out_cyc.size() > 0) check("t1_latency", out_cyc[0] - first_rd, 2);
    repeat (3) cyc();
    check("t1_drained", m_valid, 0);

    // Stalled downstream: only three reads may be taken.
    clear_log();
    m_ready = 1'b0;
    for (int i = 0; i < 6; i++) load(8'hA0 + 8'(i));
    repeat (8) cyc();
    check("t2_reads",  n_acc,     3);
    check("t2_count",  buf_count, 3);
    check("t2_rd_en",  rd_en,     0);
    check("t2_valid",  m_valid,   1);
    check("t2_head",   m_data,    8'hA0);
    m_ready = 1'b1;
    run_until(6, 20, "t2_out");
    exp_q = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
    check_log("t2", 1'b1);
    repeat (3) cyc();

    // Alternating ready.
    clear_log();
    for (int i = 0; i < 8; i++) load(8'hB0 + 8'(i));
    for (int i = 0; i < 40 && out_data.size() < 8; i++) begin
      m_ready = (i % 2 == 0);
      cyc();
    end
    check("t3_out", out_data.size(), 8);
    exp_q = '{8'hB0, 8'hB1, 8'hB2, 8'hB3, 8'hB4, 8'hB5, 8'hB6, 8'hB7};
    check_log("t3", 1'b0);
    m_ready = 1'b1;
    repeat (4) cyc();
    check("t3_no_dup", out_data.size(), 8);

    // Flush with two buffered words and one in flight.
    clear_log();
    m_ready = 1'b0;
    load(8'hC0); load(8'hC1);
    repeat (5) cyc();
    check("t4_count2", buf_count, 2);
    load(8'hC2);
    #1 check("t4_rd_pre", rd_en, 1);
    cyc();
    flush = 1'b1;
    #1 check("t4_rd_flush", rd_en, 0);
    cyc();
    flush = 1'b0;
    check("t4_count0", buf_count, 0);
    check("t4_valid0", m_valid,   0);
    exp_beat = 0;
    m_ready  = 1'b1;
    load(8'h55);
    run_until(1, 10, "t4_out");
    repeat (4) cyc();
    check("t4_only_one", out_data.size(), 1);
    exp_q = '{8'h55};
    check_log("t4", 1'b0);

    // Reset mid-packet with two words buffered.
    clear_log();
    load(8'hD0); load(8'hD1);
    run_until(2, 10, "t5_pre");
    repeat (3) cyc();
    exp_q = '{8'hD0, 8'hD1};
    check_log("t5pre", 1'b0);
    m_ready = 1'b0;
    load(8'hD2); load(8'hD3);
    repeat (5) cyc();
    check("t5_count2", buf_count, 2);
    load(8'hE0); load(8'hE1); load(8'hE2); load(8'hE3);
    rst_n = 1'b0;
    #1;
    check("t5_rd_en",  rd_en,     0);
    check("t5_valid",  m_valid,   0);
    check("t5_data",   m_data,    0);
    check("t5_last",   m_last,    0);
    check("t5_count",  buf_count, 0);
    repeat (2) cyc();
    rst_n = 1'b1;
    exp_beat = 0;
    clear_log();
    m_ready = 1'b1;
    run_until(4, 20, "t5_out");
    exp_q = '{8'hE0, 8'hE1, 8'hE2, 8'hE3};
    check_log("t5", 1'b1);
    repeat (4) cyc();
    check("t5_no_stale", out_data.size(), 4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_rd_stream.md
FIFO_RD_STREAM -- requirements
Module: fifo_rd_stream

Interface
REQ-001 Parameter DATA_W, default 8, width of the FIFO word and of m_data.
REQ-002 Parameter PKT_LEN, default 4, beats per packet for m_last generation (legal range 2..256).
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 flush  input  1  synchronous drop of all buffered and in-flight words.
REQ-006 empty  input  1  upstream synchronous FIFO empty flag.
REQ-007 data_out  input  DATA_W  upstream FIFO read data, valid the cycle after an accepted rd_en.
REQ-008 rd_en  output  1  read strobe to the upstream FIFO.
REQ-009 m_valid  output  1  output stream word valid.
REQ-010 m_ready  input  1  downstream accepts the word.
REQ-011 m_data  output  DATA_W  output stream word.
REQ-012 m_last  output  1  final beat of a PKT_LEN-beat packet.
REQ-013 buf_count  output  2  current skid-buffer occupancy (0..3).

Function
REQ-014 A read is accepted when rd_en=1 and empty=0; the word appears on data_out one cycle later and SHALL be written into the skid buffer that cycle.
REQ-015 Skid buffer depth BUF_DEPTH=3, FIFO-ordered; m_data SHALL be the head entry and m_valid SHALL equal (buf_count != 0).
REQ-016 rd_en SHALL be asserted iff empty=0, flush=0 and (buf_count + inflight) < BUF_DEPTH, where inflight is a registered copy of the previous cycle's accepted read.
REQ-017 rd_en SHALL NOT have a combinational path from m_ready or m_valid.
REQ-018 A transfer occurs when m_valid=1 and m_ready=1; the head SHALL be popped at that edge.
REQ-019 Simultaneous push and pop SHALL leave buf_count unchanged and preserve order.
REQ-020 Sustained throughput SHALL be one word per cycle when the FIFO stays non-empty and m_ready stays 1; first-word latency from rd_en to m_valid is 2 cycles.
REQ-021 The buffer SHALL never overflow; with m_ready=0 rd_en deasserts once buf_count + inflight reaches 3.
REQ-022 m_valid=1 with m_ready=0 SHALL hold m_data and m_last stable until transfer.
REQ-023 flush=1 SHALL set buf_count to 0, discard the in-flight word arriving next cycle, zero the beat counter, and force rd_en=0 that cycle.
REQ-024 An empty=1 cycle mid-stream SHALL only pause rd_en; no data loss or duplication.

Reset
REQ-025 On rst_n=0: rd_en=0, m_valid=0, m_data=0, m_last=0, buf_count=0, inflight=0, beat counter=0, asynchronously.
REQ-026 Reset asserted mid-stream SHALL discard all buffered and in-flight words; first rd_en after release no earlier than the first rising edge with rst_n=1.

Configuration
REQ-027 Macro FIFO_RD_LAST_EN: defined -> beat counter (width clog2(PKT_LEN)) counts transfers, m_last=1 on the beat where counter = PKT_LEN-1, counter wraps to 0 on that transfer.
REQ-028 FIFO_RD_LAST_EN undefined -> no beat counter, m_last tied to 0, port list unchanged.

Structure
REQ-029 Package fifo_pkg SHALL hold DATA_W default, BUF_DEPTH, PKT_LEN default and the buffer-index typedef; shared with the FIFO environment.
REQ-030 Skid buffer SHALL be sub-module fifo_rd_skid (push, pop, data, count); rd_en logic and beat counter stay in fifo_rd_stream.

Verification
REQ-031 FIFO preloaded 0x11,0x22,0x33,0x44, m_ready=1 -> m_data 0x11..0x44 on four consecutive cycles, first m_valid 2 cycles after first rd_en, m_last on 0x44 (macro on).
REQ-032 m_ready=0, 6 words in FIFO -> exactly 3 reads accepted, buf_count=3, rd_en=0; release m_ready -> all 6 words out in order, no gaps once streaming.
REQ-033 m_ready toggled 1010... over 8 words -> order preserved, each word transferred exactly once, m_data stable while stalled.
REQ-034 flush in the cycle after a read with buf_count=2 -> next cycle buf_count=0, m_valid=0, dropped word never appears; subsequent word 0x55 emerges as first beat (m_last=0).
REQ-035 rst_n pulled low with buf_count=2 mid-packet -> all outputs 0 immediately; after release next packet m_last on 4th beat.
REQ-036 Build without FIFO_RD_LAST_EN, 8 words streamed -> m_last constantly 0, data identical to REQ-031 ordering.
